// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
// Accepts a framed stream (N_hi, N_lo, 4*N big-endian payload bytes, checksum),
// writes each assembled word sequentially from address 0, and keeps the CPU
// in reset until the whole frame sums to zero mod 256.
//
// state  | meaning
// -------+------------------------------------------------------------
// HDR0   | waiting for word-count high byte
// HDR1   | waiting for word-count low byte; range check on N
// DATA   | shifting payload bytes into the word register
// WRITE  | one-cycle imem write of the assembled word, no byte accepted
// CSUM   | waiting for the checksum byte
// DONE   | frame good, CPU released
// ERR    | frame rejected, CPU held in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [15:0] CAPACITY = 16'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          n_hi;
  logic [ADDR_WIDTH:0] n_words;
  logic [ADDR_WIDTH:0] widx;
  logic [1:0]          bidx;
  logic [31:0]         word;
  logic [7:0]          sum;

  logic                xfer;
  logic [15:0]         n_full;
  logic [7:0]          sum_nxt;
  logic [ADDR_WIDTH:0] widx_inc;

  assign xfer     = in_valid & in_ready;
  assign n_full   = {n_hi, in_data};
  assign sum_nxt  = sum + in_data;
  assign widx_inc = widx + 1'b1;

  // Next-state decode; the word index is one bit wider than the address so
  // that a full-capacity frame compares against N without wrapping.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR0:  if (xfer) state_nxt = S_HDR1;
      S_HDR1: begin
        if (xfer) begin
          if (n_full > CAPACITY)  state_nxt = S_ERR;
          else if (n_full == '0)  state_nxt = S_CSUM;
          else                    state_nxt = S_DATA;
        end
      end
      S_DATA:  if (xfer && bidx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (widx_inc == n_words) ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_nxt = (sum_nxt == 8'd0) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_nxt = S_HDR0;
      S_ERR:   if (start) state_nxt = S_HDR0;
      default: state_nxt = S_HDR0;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state so
  // every output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_HDR0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_hi       <= '0;
      n_words    <= '0;
      widx       <= '0;
      bidx       <= '0;
      word       <= '0;
      sum        <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                   (state_nxt == S_DATA) || (state_nxt == S_CSUM);
      imem_we   <= (state_nxt == S_WRITE);
      done      <= (state_nxt == S_DONE);
      error     <= (state_nxt == S_ERR);
      cpu_reset <= (state_nxt != S_DONE);

      if (xfer) sum <= sum_nxt;

      case (state)
        S_HDR0: if (xfer) n_hi <= in_data;
        S_HDR1: begin
          if (xfer) begin
            n_words <= n_full[ADDR_WIDTH:0];
            widx    <= '0;
            bidx    <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word <= {word[23:0], in_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_addr  <= widx[ADDR_WIDTH-1:0];
              imem_wdata <= {word[23:0], in_data};
            end
          end
        end
        S_WRITE: widx <= widx_inc;
        S_DONE, S_ERR: if (start) sum <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are
// queued as payload bytes are driven and popped by a write monitor.
module tb_imem_loader;
  localparam int AW = 6;
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, cpu_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  logic [AW+31:0] sb[$];
  logic [AW+31:0] mon_exp;

  // Write monitor: every imem_we pulse must match the head of the scoreboard
  // and must coincide with in_ready low.
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      wr_count++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
        end
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_write: in_ready=%b, required 0", in_ready);
      end
    end
  end

  function automatic bq_t frame_of(input logic [31:0] words[$], input logic [7:0] adj);
    bq_t f;
    logic [7:0] s;
    s = 8'h00;
    f.push_back(8'(words.size() >> 8));
    f.push_back(8'(words.size()));
    foreach (words[i]) begin
      f.push_back(words[i][31:24]); f.push_back(words[i][23:16]);
      f.push_back(words[i][15:8]);  f.push_back(words[i][7:0]);
    end
    foreach (f[i]) s = s + f[i];
    f.push_back(8'(8'h00 - s + adj));
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gate_pct, output bit ok);
    int guard;
    guard = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gate_pct) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_data = b; end
      if (in_valid && in_ready) begin ok = 1'b1; return; end
      guard++;
      if (guard > 100) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_bytes(input bq_t f, input int count, input int gate_pct);
    int n;
    logic [31:0] w;
    bit ok;
    n = int'({f[0], f[1]});
    w = '0;
    for (int i = 0; i < count; i++) begin
      send_byte(f[i], gate_pct, ok);
      if (!ok) return;
      if (i >= 2 && i < 2 + 4 * n && n <= 64) begin
        w = {w[23:0], f[i]};
        if ((i - 2) % 4 == 3) sb.push_back({AW'((i - 2) / 4), w});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_end(input string name, input logic exp_done, input logic exp_err,
                           input int exp_writes, input int wr_before);
    n_checks++;
    if (done !== exp_done) begin n_fail++; $display("FAIL %s_done: %b, required %b", name, done, exp_done); end
    n_checks++;
    if (error !== exp_err) begin n_fail++; $display("FAIL %s_error: %b, required %b", name, error, exp_err); end
    n_checks++;
    if (cpu_reset !== !exp_done) begin n_fail++; $display("FAIL %s_cpu_reset: %b, required %b", name, cpu_reset, !exp_done); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_in_ready: %b, required 0", name, in_ready); end
    n_checks++;
    if (wr_count - wr_before !== exp_writes) begin
      n_fail++; $display("FAIL %s_writes: %0d, required %0d", name, wr_count - wr_before, exp_writes);
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL %s_pending: %0d writes missing, required 0", name, sb.size()); end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({in_ready, imem_we, cpu_reset, done, error} !== 5'b00100 || imem_addr !== '0 || imem_wdata !== '0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b we=%b cpu_rst=%b done=%b err=%b addr=%0d wdata=%h, required rdy=0 we=0 cpu_rst=1 done=0 err=0 addr=0 wdata=0",
               name, in_ready, imem_we, cpu_reset, done, error, imem_addr, imem_wdata);
    end
  endtask

  task automatic restart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: cpu_rst=%b done=%b err=%b rdy=%b, required 1 0 0 1", cpu_reset, done, error, in_ready);
    end
  endtask

  bq_t good_frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h54, 8'hC9};

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    check_reset_outputs("reset_values");
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_good_frame();
    int w0 = wr_count;
    send_bytes(good_frame, good_frame.size(), 0);
    check_end("good", 1'b1, 1'b0, 2, w0);
  endtask

  task automatic test_bad_checksum();
    bq_t f = good_frame;
    int w0;
    f[10] = 8'hCA;
    restart();
    w0 = wr_count;
    send_bytes(f, f.size(), 0);
    check_end("bad_csum", 1'b0, 1'b1, 2, w0);
  endtask

  task automatic test_oversize();
    bq_t f = '{8'h00, 8'h41};
    int w0;
    restart();
    w0 = wr_count;
    send_bytes(f, 2, 0);
    check_end("oversize", 1'b0, 1'b1, 0, w0);
  endtask

  task automatic test_empty();
    bq_t f = '{8'h00, 8'h00, 8'h00};
    int w0;
    restart();
    w0 = wr_count;
    send_bytes(f, 3, 0);
    check_end("empty", 1'b1, 1'b0, 0, w0);
  endtask

  task automatic test_backpressure();
    int w0;
    restart();
    w0 = wr_count;
    send_bytes(good_frame, good_frame.size(), 40);
    check_end("backpressure", 1'b1, 1'b0, 2, w0);
  endtask

  task automatic test_full_capacity();
    logic [31:0] words[$];
    bq_t f;
    int w0;
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    f = frame_of(words, 8'h00);
    restart();
    w0 = wr_count;
    send_bytes(f, f.size(), 10);
    check_end("full64", 1'b1, 1'b0, 64, w0);
  endtask

  task automatic test_reset_midframe();
    int w0;
    restart();
    w0 = wr_count;
    send_bytes(good_frame, 5, 0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk); reset_n = 1'b1;
    send_bytes(good_frame, good_frame.size(), 0);
    check_end("after_reset", 1'b1, 1'b0, 2, w0);
  endtask

  task automatic test_restart_reload();
    logic [31:0] words[$];
    bq_t f;
    int w0;
    words = '{32'h12345678, 32'h8C090004, 32'h00000000};
    f = frame_of(words, 8'h00);
    restart();
    w0 = wr_count;
    send_bytes(f, f.size(), 0);
    check_end("reload", 1'b1, 1'b0, 3, w0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_backpressure();
    test_full_capacity();
    test_reset_midframe();
    test_restart_reload();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
